// File: rtl/io_pwm_pkg.sv
// io_pwm_pkg: register offsets, CTRL bit positions and reset constants shared by io_pwm
package io_pwm_pkg;
    localparam logic [2:0] PWM_CTRL     = 3'd0;
    localparam logic [2:0] PWM_PRESCALE = 3'd1;
    localparam logic [2:0] PWM_PERIOD   = 3'd2;
    localparam logic [2:0] PWM_DUTY0    = 3'd3;
    localparam logic [2:0] PWM_DUTY1    = 3'd4;
    localparam logic [2:0] PWM_DUTY2    = 3'd5;
    localparam logic [2:0] PWM_STATUS   = 3'd6;
    localparam logic [2:0] PWM_CNT      = 3'd7;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_INV    = 2;
    localparam int CTRL_CENTER = 5;
    localparam logic [15:0] PWM_PERIOD_RST = 16'hFFFF;
endpackage

// File: rtl/io_pwm_chan.sv
// io_pwm_chan: one PWM channel with double-buffered duty, compare, polarity and output flop
module io_pwm_chan
    import io_pwm_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic          load,
    input  logic          en,
    input  logic          inv,
    input  logic [CW-1:0] wdata,
    input  logic [CW-1:0] cnt,
    output logic [CW-1:0] duty,
    output logic          out
);
    logic [CW-1:0] duty_act;

    // shadow follows the bus; active copy only moves when the top says it is glitch-safe
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            duty     <= '0;
            duty_act <= '0;
            out      <= 1'b0;
        end else begin
            if (wr) duty <= wdata;
            if (load) duty_act <= duty;
            out <= (en && cnt < duty_act) ^ inv;
        end
endmodule

// File: rtl/io_pwm.sv
// io_pwm: three-channel PWM on the word-addressed IO bus, spliced into the read-data chain
// Optional: PWM_CENTER_ALIGN_EN adds CTRL[5] center-aligned (up/down) counting.
module io_pwm
    import io_pwm_pkg::*;
#(
    parameter logic [13:0] PWM_BASE = 14'h0040,
    parameter int          CW       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic [2:0]  pwm_out,
    output logic        pwm_irq
);
    logic          en, irq_en, center;
    logic [2:0]    inv;
    logic [CW-1:0] prescale, period, period_act, pre, cnt, cnt_nxt;
    logic          pending, wrap_flag, hit_q;
    logic [31:0]   rdata_q, rval;
    logic [13:0]   woff, roff;
    logic          wsel, rsel, tick, wrap, load, sh_wr;
    logic [CW-1:0] duty [3];
    logic          unused;

    assign woff   = dma_io_wadr - PWM_BASE;
    assign roff   = dma_io_radr - PWM_BASE;
    assign wsel   = dma_io_we && woff < 14'd8;
    assign rsel   = dma_io_radr_en && roff < 14'd8;
    assign sh_wr  = wsel && woff[2:0] >= PWM_PERIOD && woff[2:0] <= PWM_DUTY2;
    assign tick   = en && pre >= prescale;
    assign load   = !en || wrap;
    assign unused = ^dma_io_wdata[31:CW];
    assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;

`ifdef PWM_CENTER_ALIGN_EN
    logic down;

    assign wrap = tick && (center ? down && cnt == '0 : cnt == period_act);

    // next count: edge mode wraps to zero, center mode reflects at both ends
    always_comb begin
        cnt_nxt = cnt == period_act ? '0 : cnt + 1'b1;
        if (center)
            cnt_nxt = down ? (cnt == '0 ? (period_act == '0 ? '0 : CW'(1)) : cnt - 1'b1)
                           : (cnt == period_act ? (period_act == '0 ? '0 : cnt - 1'b1) : cnt + 1'b1);
    end

    // CTRL[5] and count direction; direction restarts upward whenever center mode is off
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            center <= 1'b0;
            down   <= 1'b0;
        end else begin
            if (wsel && woff[2:0] == PWM_CTRL) center <= dma_io_wdata[CTRL_CENTER];
            if (!en || !center) down <= 1'b0;
            else if (tick) down <= down ? cnt != '0 : cnt == period_act;
        end
`else
    assign center  = 1'b0;
    assign wrap    = tick && cnt == period_act;
    assign cnt_nxt = cnt == period_act ? '0 : cnt + 1'b1;
`endif

    // control, prescale and period registers, plus pending/wrap status and the interrupt flop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            en         <= 1'b0;
            irq_en     <= 1'b0;
            inv        <= 3'b000;
            prescale   <= '0;
            period     <= CW'(PWM_PERIOD_RST);
            period_act <= CW'(PWM_PERIOD_RST);
            pending    <= 1'b0;
            wrap_flag  <= 1'b0;
            pwm_irq    <= 1'b0;
        end else begin
            if (wsel && woff[2:0] == PWM_CTRL) begin
                en     <= dma_io_wdata[CTRL_EN];
                irq_en <= dma_io_wdata[CTRL_IRQ_EN];
                inv    <= dma_io_wdata[CTRL_INV+:3];
            end
            if (wsel && woff[2:0] == PWM_PRESCALE) prescale <= dma_io_wdata[CW-1:0];
            if (wsel && woff[2:0] == PWM_PERIOD) period <= dma_io_wdata[CW-1:0];
            if (load) period_act <= period;
            pending   <= !en ? 1'b0 : sh_wr ? 1'b1 : wrap ? 1'b0 : pending;
            wrap_flag <= wrap ? 1'b1 : (wsel && woff[2:0] == PWM_STATUS && dma_io_wdata[0]) ? 1'b0 : wrap_flag;
            pwm_irq   <= wrap_flag & irq_en;
        end

    // prescaler and period counter; both sit at zero while disabled
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else if (!en) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            cnt <= cnt_nxt;
        end else begin
            pre <= pre + 1'b1;
        end

    // register read mux; unused bits read as zero
    always_comb begin
        rval = '0;
        case (roff[2:0])
            PWM_CTRL:     rval[5:0]    = {center, inv, irq_en, en};
            PWM_PRESCALE: rval[CW-1:0] = prescale;
            PWM_PERIOD:   rval[CW-1:0] = period;
            PWM_DUTY0:    rval[CW-1:0] = duty[0];
            PWM_DUTY1:    rval[CW-1:0] = duty[1];
            PWM_DUTY2:    rval[CW-1:0] = duty[2];
            PWM_STATUS:   rval[1:0]    = {pending, wrap_flag};
            default:      rval[CW-1:0] = cnt;
        endcase
    end

    // one-cycle read capture; a miss lets upstream data through the chain
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hit_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            hit_q <= rsel;
            if (rsel) rdata_q <= rval;
        end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        io_pwm_chan #(.CW(CW)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wsel && woff[2:0] == PWM_DUTY0 + 3'(c)),
            .load  (load),
            .en    (en),
            .inv   (inv[c]),
            .wdata (dma_io_wdata[CW-1:0]),
            .cnt   (cnt),
            .duty  (duty[c]),
            .out   (pwm_out[c])
        );
    end
endmodule

// File: tb/tb_io_pwm.sv
// tb_io_pwm: randomized and directed checks of io_pwm against a closed-form waveform model
module tb_io_pwm;
    localparam logic [13:0] BASE = 14'h0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dma_io_we = 1'b0;
    logic [13:0] dma_io_wadr = '0;
    logic [31:0] dma_io_wdata = '0;
    logic [13:0] dma_io_radr = '0;
    logic        dma_io_radr_en = 1'b0;
    logic [31:0] dma_io_rdata_in = 32'hA5A5A5A5;
    logic [31:0] dma_io_rdata;
    logic [2:0]  pwm_out;
    logic        pwm_irq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int e0 = 0;
    int last = 0;
    int m_ps, m_per, m_jw, m_chg_ch, m_new;
    int m_duty [3];
    logic [2:0] m_inv;

    io_pwm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_radr_en  (dma_io_radr_en),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .pwm_out         (pwm_out),
        .pwm_irq         (pwm_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after the k-th edge following the enable write: the output shows the
    // counter of the previous cycle; counter advances once per PRESCALE+1 clocks modulo PERIOD+1;
    // a duty rewrite applies from the first period that starts after the write.
    function automatic logic [2:0] exp_out(input int k);
        logic [2:0] r;
        int c, l, cnt, d;
        c = k - 1;
        l = (m_ps + 1) * (m_per + 1);
        cnt = (c / (m_ps + 1)) % (m_per + 1);
        for (int n = 0; n < 3; n++) begin
            d = (n == m_chg_ch && c / l > m_jw / l) ? m_new : m_duty[n];
            r[n] = (cnt < d) ^ m_inv[n];
        end
        return r;
    endfunction

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        dma_io_we = 1'b1;
        dma_io_wadr = BASE + {11'd0, off};
        dma_io_wdata = d;
        @(posedge clk);
        #1 dma_io_we = 1'b0;
        last = cyc;
    endtask

    task automatic rd(input logic [13:0] adr, output logic [31:0] d);
        @(negedge clk);
        dma_io_radr_en = 1'b1;
        dma_io_radr = adr;
        @(posedge clk);
        #1 dma_io_radr_en = 1'b0;
        d = dma_io_rdata;
    endtask

    task automatic start(input int ps, input int per, input int d0, input int d1, input int d2,
                         input logic [2:0] inv, input logic ie);
        wr(3'd0, 32'd0);
        wr(3'd6, 32'd1);
        wr(3'd1, 32'(ps));
        wr(3'd2, 32'(per));
        wr(3'd3, 32'(d0));
        wr(3'd4, 32'(d1));
        wr(3'd5, 32'(d2));
        m_ps = ps; m_per = per; m_inv = inv; m_chg_ch = -1; m_jw = 0; m_new = 0;
        m_duty[0] = d0; m_duty[1] = d1; m_duty[2] = d2;
        wr(3'd0, {27'd0, inv, ie, 1'b1});
        e0 = last;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (pwm_out !== 3'b000 || pwm_irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs pwm_out=%b pwm_irq=%b want 000/0", pwm_out, pwm_irq);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(BASE + 14'(i), d);
            tests++;
            if (d !== (i == 2 ? 32'h0000FFFF : 32'h0)) begin
                fails++;
                $display("FAIL reset_read off=%0d got=%h want=%h", i, d, (i == 2 ? 32'h0000FFFF : 32'h0));
            end
        end
        rd(BASE + 14'd8, d);
        tests++;
        if (d !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL passthru_above got=%h want=a5a5a5a5", d);
        end
        rd(BASE - 14'd1, d);
        tests++;
        if (d !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL passthru_below got=%h want=a5a5a5a5", d);
        end
        @(negedge clk) dma_io_radr = BASE + 14'd2;
        @(posedge clk);
        #1;
        tests++;
        if (dma_io_rdata !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL no_strobe got=%h want=a5a5a5a5", dma_io_rdata);
        end
    endtask

    task automatic test_edge_pwm();
        logic [31:0] d;
        int ps, per, n;
        logic [2:0] inv;
        start(0, 9, 3, 0, 0, 3'b000, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (pwm_out !== exp_out(cyc - e0)) begin
                fails++;
                $display("FAIL pwm_basic k=%0d pwm_out=%b want=%b", cyc - e0, pwm_out, exp_out(cyc - e0));
            end
        end
        start(1, 0, 1, 0, 5, 3'b000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (pwm_out !== exp_out(cyc - e0)) begin
                fails++;
                $display("FAIL pwm_period0 k=%0d pwm_out=%b want=%b", cyc - e0, pwm_out, exp_out(cyc - e0));
            end
        end
        for (int r = 0; r < 6; r++) begin
            ps = int'($urandom_range(0, 3));
            per = int'($urandom_range(0, 12));
            inv = 3'($urandom_range(0, 7));
            start(ps, per, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), inv, 1'b0);
            rd(BASE + 14'd2, d);
            tests++;
            if (d !== 32'(per)) begin
                fails++;
                $display("FAIL readback_period got=%h want=%h", d, 32'(per));
            end
            rd(BASE, d);
            tests++;
            if (d !== {27'd0, inv, 2'b01}) begin
                fails++;
                $display("FAIL readback_ctrl got=%h want=%h", d, {27'd0, inv, 2'b01});
            end
            n = 2 * (ps + 1) * (per + 1) + 4;
            for (int i = 0; i < n; i++) begin
                @(posedge clk);
                #1;
                tests++;
                if (pwm_out !== exp_out(cyc - e0)) begin
                    fails++;
                    $display("FAIL pwm_random ps=%0d per=%0d k=%0d pwm_out=%b want=%b",
                             ps, per, cyc - e0, pwm_out, exp_out(cyc - e0));
                end
            end
        end
    endtask

    task automatic test_duty_update();
        logic [31:0] d;
        start(0, 9, 3, 0, 0, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        wr(3'd3, 32'd7);
        m_jw = last - e0;
        m_chg_ch = 0;
        m_new = 7;
        rd(BASE + 14'd6, d);
        tests++;
        if (d[1] !== 1'b1) begin
            fails++;
            $display("FAIL pending_set got=%b want=1", d[1]);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (pwm_out !== exp_out(cyc - e0)) begin
                fails++;
                $display("FAIL duty_update k=%0d pwm_out=%b want=%b", cyc - e0, pwm_out, exp_out(cyc - e0));
            end
        end
        rd(BASE + 14'd6, d);
        tests++;
        if (d[1] !== 1'b0) begin
            fails++;
            $display("FAIL pending_clear got=%b want=0", d[1]);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int k;
        start(3, 1, 0, 0, 0, 3'b000, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            k = cyc - e0;
            tests++;
            if (pwm_irq !== (k >= 9)) begin
                fails++;
                $display("FAIL irq_first k=%0d pwm_irq=%b want=%b", k, pwm_irq, k >= 9);
            end
        end
        wr(3'd6, 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            k = cyc - e0;
            tests++;
            if (pwm_irq !== (k >= 17)) begin
                fails++;
                $display("FAIL irq_w1c k=%0d pwm_irq=%b want=%b", k, pwm_irq, k >= 17);
            end
        end
        while ((cyc - e0) % 8 != 7) begin
            @(posedge clk);
            #1;
        end
        wr(3'd6, 32'd1);
        rd(BASE + 14'd6, d);
        tests++;
        if (d[0] !== 1'b1) begin
            fails++;
            $display("FAIL w1c_vs_wrap flag=%b want=1", d[0]);
        end
        tests++;
        if (pwm_irq !== 1'b1) begin
            fails++;
            $display("FAIL w1c_vs_wrap_irq pwm_irq=%b want=1", pwm_irq);
        end
    endtask

    task automatic test_invert();
        start(0, 9, 0, 20, 0, 3'b111, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (pwm_out !== 3'b101) begin
                fails++;
                $display("FAIL invert k=%0d pwm_out=%b want=101", cyc - e0, pwm_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        start(0, 9, 10, 0, 0, 3'b000, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        tests++;
        if (pwm_out !== 3'b001 || pwm_irq !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset pwm_out=%b pwm_irq=%b want 001/1", pwm_out, pwm_irq);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (pwm_out !== 3'b000 || pwm_irq !== 1'b0) begin
            fails++;
            $display("FAIL async_reset pwm_out=%b pwm_irq=%b want 000/0", pwm_out, pwm_irq);
        end
        @(negedge clk) rst_n = 1'b1;
        rd(BASE + 14'd7, d);
        tests++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt got=%h want=0", d);
        end
        rd(BASE, d);
        tests++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL reset_ctrl got=%h want=0", d);
        end
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (pwm_out !== 3'b000) begin
            fails++;
            $display("FAIL idle_out pwm_out=%b want=000", pwm_out);
        end
        rd(BASE + 14'd7, d);
        tests++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL idle_cnt got=%h want=0", d);
        end
    endtask

    initial begin
        test_reset();
        test_edge_pwm();
        test_duty_update();
        test_irq();
        test_invert();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
